regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Writeback arbiter and scoreboard in front of the 32×64-bit register file. It shares the register file's single write port between the ALU writeback path (requester A) and the load writeback path (requester B), and registers the winning write onto the port. It also tracks in-flight destination registers and flags read-after-write hazards on the two decode-stage read addresses so the pipeline can stall, or forward when forwarding is compiled in.

## Interface
Parameters:
- DATA_W, 64, register data width
- ADDR_W, 5, register address width (32 registers, x0 hardwired zero)
- CNT_W, 2, width of per-register in-flight counter (max 3 outstanding writes per register)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- a_valid / a_ready  in / out  1 / 1  ALU writeback handshake
- a_rd, a_data  in  ADDR_W, DATA_W  ALU destination and result
- b_valid / b_ready  in / out  1 / 1  load writeback handshake
- b_rd, b_data  in  ADDR_W, DATA_W  load destination and data
- rsv_valid / rsv_ready  in / out  1 / 1  issue-side reservation of a destination register
- rsv_rd  in  ADDR_W  register being reserved
- rs1, rs2  in  ADDR_W  decode read addresses
- hazard1, hazard2  out  1  read of rs1/rs2 must stall
- fwd1_valid, fwd2_valid  out  1  bypass data valid (forwarding build only)
- fwd1_data, fwd2_data  out  DATA_W  bypass data
- rf_we  out  1  register file write enable (registered)
- rf_rd  out  ADDR_W  register file write address (registered)
- rf_wdata  out  DATA_W  register file write data (registered)

## Operation
- A transfer occurs when valid and ready are both high at a rising edge.
- Arbitration:
  - Single valid requester is granted.
  - Both valid: grant the requester not granted last (round-robin). last_grant updates only on an actual transfer.
  - x_ready = grant_x. It is combinational from the valid inputs and never high without the matching valid.
- Write stage: an accepted request loads rf_rd/rf_wdata and sets rf_we=1 for exactly one cycle.
  - rf_we=0 when nothing is accepted.
  - A request with rd==0 is accepted, but rf_we stays 0 and no counter is touched.
- Scoreboard: one CNT_W-bit counter per register 1..31.
  - Reservation with rsv_rd!=0 increments the counter.
  - A committed write (rf_we=1) decrements the counter for rf_rd.
  - Same register, same cycle: increment and decrement cancel (net 0).
  - rsv_ready=0 while the counter for rsv_rd is at its maximum (3) with no decrement this cycle. rsv_rd==0 is always ready and ignored.
  - Decrementing a zero counter is a protocol error: the counter holds at 0.
- hazardN = (rsN!=0) && (count[rsN]!=0). Combinational from current state.

## Timing
- Reset (reset=0) clears immediately, regardless of clock: rf_we=0, rf_rd=0, rf_wdata=0, all counters 0, last_grant=B (so A wins the first tie). All hazard and fwd outputs are 0.
- Latency: request accepted at edge N; rf_we high during cycle N to N+1; register file written at edge N+1; counter decremented at edge N+1.
- Throughput: one write per cycle. The loser of a tie waits exactly one cycle if it holds valid.
- Requesters must hold valid, rd and data stable until ready. The block does not buffer unaccepted requests.
- Reset asserted mid-transfer discards the pending write (rf_we forced 0). Requesters must re-reserve after reset.

## Configuration
- REGFILE_ARB_FWD_EN defined: if rf_we=1, rf_rd==rsN!=0 and count[rsN]==1, then:
  - hazardN=0
  - fwdN_valid=1
  - fwdN_data=rf_wdata
- With count>1 the hazard stays asserted (an older write is in flight).
- REGFILE_ARB_FWD_EN undefined: fwdN_valid=0, fwdN_data=0, and the hazard follows the base rule only.

## Structure
- Shared package regfile_arb_pkg holds:
  - DATA_W, ADDR_W, CNT_W, NUM_REGS=32
  - wb_req_t struct (valid, rd, data)
  - CNT_MAX constant
- Sub-module regfile_scoreboard holds the counter array, rsv_ready, hazard and forwarding logic.
- The top level holds the arbiter and the write-port register.

## Test plan
- Reset: hold reset=0 with a_valid=1 → rf_we=0, all hazards 0. Release reset → the first write appears one cycle after acceptance.
- Tie: a(rd=5, data=0xAA) and b(rd=6, data=0xBB) both valid for 2 cycles → A granted first, then B; rf_we carries rd 5 then rd 6 on consecutive cycles.
- Scoreboard: reserve rd=7 three times, then a fourth time → rsv_ready=0 on the fourth; rs1=7 gives hazard1=1 until three writes to 7 commit, then hazard1=0.
- x0: reserve rd=0 and a write to rd=0 → rf_we stays 0, rsv_ready=1, hazards 0.
- Same-cycle reserve and commit on rd=9 at count=1 → count stays 1 and hazard on rs2=9 persists.
- FWD_EN: count[3]=1, write rd=3 data=0x1234 committing, rs1=3 → hazard1=0, fwd1_valid=1, fwd1_data=0x1234. Without the macro, hazard1=1 in the same cycle.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_arb_pkg
//  Description : Shared widths, request struct and grant encoding for the
//                register-file writeback arbiter and scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_arb_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int CNT_W    = 2;
  localparam int NUM_REGS = 32;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter_if
//  Description : Writeback, reservation, hazard/bypass and register-file
//                write-port signals of the writeback arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if;
  import regfile_arb_pkg::*;

  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_rd;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_rd;
  logic [DATA_W-1:0] b_data;
  logic              rsv_valid;
  logic              rsv_ready;
  logic [ADDR_W-1:0] rsv_rd;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic              hazard1;
  logic              hazard2;
  logic              fwd1_valid;
  logic              fwd2_valid;
  logic [DATA_W-1:0] fwd1_data;
  logic [DATA_W-1:0] fwd2_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_wdata;

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  rsv_valid, rsv_rd, rs1, rs2,
    output a_ready, b_ready, rsv_ready, hazard1, hazard2,
    output fwd1_valid, fwd2_valid, fwd1_data, fwd2_data,
    output rf_we, rf_rd, rf_wdata
  );

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output rsv_valid, rsv_rd, rs1, rs2,
    input  a_ready, b_ready, rsv_ready, hazard1, hazard2,
    input  fwd1_valid, fwd2_valid, fwd1_data, fwd2_data,
    input  rf_we, rf_rd, rf_wdata
  );

endinterface
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Per-register in-flight write counters, reservation back-
//                pressure and RAW hazard detection. Bypass from the write
//                port is compiled in with REGFILE_ARB_FWD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
  import regfile_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              rsv_valid_i,
  input  logic [ADDR_W-1:0] rsv_rd_i,
  output logic              rsv_ready_o,
  input  logic              commit_we_i,
  input  logic [ADDR_W-1:0] commit_rd_i,
  input  logic [DATA_W-1:0] commit_data_i,
  input  logic [ADDR_W-1:0] rs1_i,
  input  logic [ADDR_W-1:0] rs2_i,
  output logic              hazard1_o,
  output logic              hazard2_o,
  output logic              fwd1_valid_o,
  output logic              fwd2_valid_o,
  output logic [DATA_W-1:0] fwd1_data_o,
  output logic [DATA_W-1:0] fwd2_data_o
);

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt_q;
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt_d;
  logic                           rsv_inc;
  logic                           same_reg;

  // A full counter can still accept a reservation when it drains this cycle.
  always_comb begin
    rsv_ready_o = (rsv_rd_i == '0) || (cnt_q[rsv_rd_i] != CNT_MAX) ||
                  (commit_we_i && (commit_rd_i == rsv_rd_i));
    rsv_inc     = rsv_valid_i && rsv_ready_o && (rsv_rd_i != '0);
    same_reg    = rsv_inc && commit_we_i && (commit_rd_i == rsv_rd_i);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (rsv_inc && !same_reg) begin
      cnt_d[rsv_rd_i] = cnt_q[rsv_rd_i] + 1'b1;
    end
    if (commit_we_i && !same_reg && (commit_rd_i != '0) &&
        (cnt_q[commit_rd_i] != '0)) begin
      cnt_d[commit_rd_i] = cnt_q[commit_rd_i] - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    hazard1_o    = (rs1_i != '0) && (cnt_q[rs1_i] != '0);
    hazard2_o    = (rs2_i != '0) && (cnt_q[rs2_i] != '0);
    fwd1_valid_o = 1'b0;
    fwd2_valid_o = 1'b0;
    fwd1_data_o  = '0;
    fwd2_data_o  = '0;
`ifdef REGFILE_ARB_FWD_EN
    // Only the youngest outstanding write may be bypassed.
    if (commit_we_i && (rs1_i != '0) && (commit_rd_i == rs1_i) &&
        (cnt_q[rs1_i] == CNT_W'(1))) begin
      hazard1_o    = 1'b0;
      fwd1_valid_o = 1'b1;
      fwd1_data_o  = commit_data_i;
    end
    if (commit_we_i && (rs2_i != '0) && (commit_rd_i == rs2_i) &&
        (cnt_q[rs2_i] == CNT_W'(1))) begin
      hazard2_o    = 1'b0;
      fwd2_valid_o = 1'b1;
      fwd2_data_o  = commit_data_i;
    end
`endif
  end

`ifdef REGFILE_ARB_FWD_EN
`else
  logic unused_commit_data;
  assign unused_commit_data = ^commit_data_i;
`endif

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Round-robin arbiter sharing the register-file write port
//                between ALU (A) and load (B) writeback, with a registered
//                write stage and an in-flight scoreboard. Define
//                REGFILE_ARB_FWD_EN to enable bypass from the write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
  import regfile_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus
);

  wb_req_t           req_a;
  wb_req_t           req_b;
  wb_req_t           win;
  logic              grant_a;
  logic              grant_b;
  logic              xfer;
  grant_e            last_grant_q;
  grant_e            last_grant_d;
  logic              rf_we_q;
  logic              rf_we_d;
  logic [ADDR_W-1:0] rf_rd_q;
  logic [ADDR_W-1:0] rf_rd_d;
  logic [DATA_W-1:0] rf_wdata_q;
  logic [DATA_W-1:0] rf_wdata_d;

  assign req_a = '{valid: bus.a_valid, rd: bus.a_rd, data: bus.a_data};
  assign req_b = '{valid: bus.b_valid, rd: bus.b_rd, data: bus.b_data};

  // x0 writes are accepted to free the requester but never reach the port.
  always_comb begin
    grant_a      = req_a.valid && (!req_b.valid || (last_grant_q == GRANT_B));
    grant_b      = req_b.valid && (!req_a.valid || (last_grant_q == GRANT_A));
    xfer         = grant_a || grant_b;
    win          = grant_a ? req_a : req_b;
    last_grant_d = last_grant_q;
    rf_we_d      = 1'b0;
    rf_rd_d      = rf_rd_q;
    rf_wdata_d   = rf_wdata_q;
    if (xfer) begin
      last_grant_d = grant_a ? GRANT_A : GRANT_B;
      rf_we_d      = (win.rd != '0);
      rf_rd_d      = win.rd;
      rf_wdata_d   = win.data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= GRANT_B;
      rf_we_q      <= 1'b0;
      rf_rd_q      <= '0;
      rf_wdata_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_rd_q      <= rf_rd_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  assign bus.a_ready  = grant_a;
  assign bus.b_ready  = grant_b;
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_rd    = rf_rd_q;
  assign bus.rf_wdata = rf_wdata_q;

  regfile_scoreboard u_scoreboard (
    .clk           (clk),
    .reset         (reset),
    .rsv_valid_i   (bus.rsv_valid),
    .rsv_rd_i      (bus.rsv_rd),
    .rsv_ready_o   (bus.rsv_ready),
    .commit_we_i   (rf_we_q),
    .commit_rd_i   (rf_rd_q),
    .commit_data_i (rf_wdata_q),
    .rs1_i         (bus.rs1),
    .rs2_i         (bus.rs2),
    .hazard1_o     (bus.hazard1),
    .hazard2_o     (bus.hazard2),
    .fwd1_valid_o  (bus.fwd1_valid),
    .fwd2_valid_o  (bus.fwd2_valid),
    .fwd1_data_o   (bus.fwd1_data),
    .fwd2_data_o   (bus.fwd2_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_arbiter
//  Description : Randomized self-checking bench for regfile_wb_arbiter with a
//                behavioural model and an expected-write queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;
  import regfile_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                rd;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t               exp_q[$];
  int                checks   = 0;
  int                failures = 0;
  int                m_cnt[NUM_REGS];
  bit                m_last_b;
  bit                m_we;
  int                m_rd;
  logic [DATA_W-1:0] m_data;
  bit                a_pend;
  bit                b_pend;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int r = 0; r < NUM_REGS; r++) m_cnt[r] = 0;
    m_last_b = 1'b1;
    m_we     = 1'b0;
    m_rd     = 0;
    m_data   = '0;
    a_pend   = 1'b0;
    b_pend   = 1'b0;
  endfunction

  function automatic void exp_haz(input int rs, output bit h, output bit fv,
                                  output logic [DATA_W-1:0] fd);
    h  = (rs != 0) && (m_cnt[rs] != 0);
    fv = 1'b0;
    fd = '0;
`ifdef REGFILE_ARB_FWD_EN
    if (m_we && (m_rd == rs) && (rs != 0) && (m_cnt[rs] == 1)) begin
      h  = 1'b0;
      fv = 1'b1;
      fd = m_data;
    end
`endif
  endfunction

  // Write-port monitor: every committed write must match the oldest expected one.
  always @(negedge clk) begin
    wr_t e;
    if (reset === 1'b1 && bus.rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rf_write_unexpected: got rd=%0d data=%0h expected no write",
                 bus.rf_rd, bus.rf_wdata);
      end else begin
        e = exp_q.pop_front();
        check("rf_rd", 64'(bus.rf_rd), 64'(e.rd));
        check("rf_wdata", bus.rf_wdata, e.data);
      end
    end
  end

  // Evaluate one cycle: compare combinational outputs, predict, then clock.
  task automatic step();
    bit                ga, gb, rr, h1, h2, f1, f2;
    logic [DATA_W-1:0] d1, d2;
    int                rsv_rd, wr_rd;
    wr_t               w;
    #1;
    ga     = bus.a_valid && (!bus.b_valid || m_last_b);
    gb     = bus.b_valid && !ga;
    rsv_rd = int'(bus.rsv_rd);
    rr     = (rsv_rd == 0) || (m_cnt[rsv_rd] < 3) || (m_we && m_rd == rsv_rd);
    exp_haz(int'(bus.rs1), h1, f1, d1);
    exp_haz(int'(bus.rs2), h2, f2, d2);
    check("a_ready", 64'(bus.a_ready), 64'(ga));
    check("b_ready", 64'(bus.b_ready), 64'(gb));
    check("rsv_ready", 64'(bus.rsv_ready), 64'(rr));
    check("hazard1", 64'(bus.hazard1), 64'(h1));
    check("hazard2", 64'(bus.hazard2), 64'(h2));
    check("fwd1_valid", 64'(bus.fwd1_valid), 64'(f1));
    check("fwd2_valid", 64'(bus.fwd2_valid), 64'(f2));
    check("fwd1_data", bus.fwd1_data, d1);
    check("fwd2_data", bus.fwd2_data, d2);

    wr_rd = ga ? int'(bus.a_rd) : int'(bus.b_rd);
    if ((ga || gb) && wr_rd != 0) begin
      w.rd   = wr_rd;
      w.data = ga ? bus.a_data : bus.b_data;
      exp_q.push_back(w);
    end
    if (bus.rsv_valid && rr && rsv_rd != 0) m_cnt[rsv_rd]++;
    if (m_we && m_cnt[m_rd] > 0) m_cnt[m_rd]--;
    m_we   = (ga || gb) && wr_rd != 0;
    m_rd   = wr_rd;
    m_data = ga ? bus.a_data : bus.b_data;
    if (ga) m_last_b = 1'b0;
    if (gb) m_last_b = 1'b1;
    a_pend = bus.a_valid && !ga;
    b_pend = bus.b_valid && !gb;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit av, input int ard, input logic [DATA_W-1:0] ad,
                       input bit bv, input int brd, input logic [DATA_W-1:0] bd,
                       input bit rv, input int rrd, input int r1, input int r2);
    bus.a_valid   = av;
    bus.a_rd      = ADDR_W'(ard);
    bus.a_data    = ad;
    bus.b_valid   = bv;
    bus.b_rd      = ADDR_W'(brd);
    bus.b_data    = bd;
    bus.rsv_valid = rv;
    bus.rsv_rd    = ADDR_W'(rrd);
    bus.rs1       = ADDR_W'(r1);
    bus.rs2       = ADDR_W'(r2);
    step();
  endtask

  task automatic random_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      if (!a_pend) begin
        bus.a_valid = 1'($urandom_range(0, 1));
        bus.a_rd    = ADDR_W'($urandom_range(0, 7));
        bus.a_data  = {$urandom, $urandom};
      end
      if (!b_pend) begin
        bus.b_valid = 1'($urandom_range(0, 1));
        bus.b_rd    = ADDR_W'($urandom_range(0, 7));
        bus.b_data  = {$urandom, $urandom};
      end
      bus.rsv_valid = 1'($urandom_range(0, 1));
      bus.rsv_rd    = ADDR_W'($urandom_range(0, 7));
      bus.rs1       = ADDR_W'($urandom_range(0, 7));
      bus.rs2       = ADDR_W'($urandom_range(0, 7));
      step();
    end
  endtask

  initial begin
    model_reset();
    reset = 1'b0;
    drive(0, 0, '0, 0, 0, '0, 0, 0, 0, 0);
    bus.a_valid = 1'b1;
    bus.a_rd    = 5'd4;
    bus.a_data  = 64'h44;
    bus.rs1     = 5'd7;
    bus.rs2     = 5'd9;
    repeat (2) @(posedge clk);
    #2;
    check("reset_rf_we", 64'(bus.rf_we), 64'd0);
    check("reset_rf_rd", 64'(bus.rf_rd), 64'd0);
    check("reset_rf_wdata", bus.rf_wdata, 64'd0);
    check("reset_hazard1", 64'(bus.hazard1), 64'd0);
    check("reset_hazard2", 64'(bus.hazard2), 64'd0);
    check("reset_fwd1_valid", 64'(bus.fwd1_valid), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Tie right after reset: A first, then B.
    drive(1, 5, 64'hAA, 1, 6, 64'hBB, 0, 0, 0, 0);
    drive(0, 0, '0, 1, 6, 64'hBB, 0, 0, 0, 0);
    drive(0, 0, '0, 0, 0, '0, 0, 0, 0, 0);

    // Fill rd=7 to the limit, then drain it with three writes.
    repeat (4) drive(0, 0, '0, 0, 0, '0, 1, 7, 7, 0);
    drive(1, 7, 64'h71, 0, 0, '0, 0, 0, 7, 0);
    drive(0, 0, '0, 1, 7, 64'h72, 1, 7, 7, 0);
    drive(1, 7, 64'h73, 0, 0, '0, 0, 0, 7, 0);
    drive(0, 0, '0, 0, 0, '0, 0, 0, 7, 0);
    drive(1, 7, 64'h74, 0, 0, '0, 0, 0, 7, 0);
    repeat (2) drive(0, 0, '0, 0, 0, '0, 0, 0, 7, 0);

    // x0 reservation and write are ignored.
    drive(1, 0, 64'h55, 0, 0, '0, 1, 0, 0, 0);
    drive(0, 0, '0, 0, 0, '0, 0, 0, 0, 0);

    // Same-cycle reserve and commit on rd=9.
    drive(0, 0, '0, 0, 0, '0, 1, 9, 0, 9);
    drive(1, 9, 64'h99, 0, 0, '0, 0, 0, 0, 9);
    drive(0, 0, '0, 0, 0, '0, 1, 9, 0, 9);
    drive(0, 0, '0, 0, 0, '0, 0, 0, 0, 9);
    drive(0, 0, '0, 1, 9, 64'h9A, 0, 0, 0, 9);
    drive(0, 0, '0, 0, 0, '0, 0, 0, 0, 9);

    // Bypass opportunity on rd=3 with a single outstanding write.
    drive(0, 0, '0, 0, 0, '0, 1, 3, 0, 0);
    drive(1, 3, 64'h1234, 0, 0, '0, 0, 0, 3, 3);
    drive(0, 0, '0, 0, 0, '0, 0, 0, 3, 3);

    random_cycles(300);

    // Reset while a write sits on the port.
    drive(0, 0, '0, 0, 0, '0, 1, 2, 2, 0);
    drive(1, 2, 64'hDEAD, 0, 0, '0, 0, 0, 2, 0);
    #3;
    reset = 1'b0;
    #1;
    check("midreset_rf_we", 64'(bus.rf_we), 64'd0);
    check("midreset_hazard1", 64'(bus.hazard1), 64'd0);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.rsv_valid = 1'b0;
    exp_q.delete();
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    random_cycles(200);
    repeat (3) drive(0, 0, '0, 0, 0, '0, 0, 0, 0, 0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
